// File: rtl/unpack_align.sv
// Half-precision adder front end: unpacks two operands, classifies specials,
// orders them by magnitude and right-aligns the smaller mantissa with sticky.
module unpack_align #(
  parameter int MAX_SHIFT = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] man_big,
  output logic [15:0] man_small,
  output logic [5:0]  exp,
  output logic        sign_big,
  output logic        eff_sub,
  output logic        swapped,
  output logic [1:0]  exception
);

  typedef enum logic [1:0] {IDLE, UNPACK, ALIGN, DONE} state_t;

  localparam logic [4:0] MAX_D = 5'(MAX_SHIFT);

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic [15:0] man_big_q, man_big_d, man_small_q, man_small_d;
  logic [5:0]  exp_q, exp_d;
  logic        sign_big_q, sign_big_d, eff_sub_q, eff_sub_d, swapped_q, swapped_d;
  logic [1:0]  exception_q, exception_d;

  logic [4:0]  ea, eb, e_big, e_small, d;
  logic [15:0] ma, mb;
  logic        a_big, nan_any, inf_any;

  // One right shift; the bit falling off is ORed into the sticky position.
  function automatic logic [15:0] sticky_shr1(input logic [15:0] m);
    return {1'b0, m[15:2], m[1] | m[0]};
  endfunction

  function automatic logic [15:0] sticky_flush(input logic [15:0] m);
    return {15'b0, |m};
  endfunction

  always_comb begin
    // Zero exponent field means denormal/zero: no hidden bit, effective exponent 1.
    ea      = (a_q[14:10] == 5'd0) ? 5'd1 : a_q[14:10];
    eb      = (b_q[14:10] == 5'd0) ? 5'd1 : b_q[14:10];
    ma      = {2'b00, |a_q[14:10], a_q[9:0], 3'b000};
    mb      = {2'b00, |b_q[14:10], b_q[9:0], 3'b000};
    a_big   = {ea, ma} >= {eb, mb};
    e_big   = a_big ? ea : eb;
    e_small = a_big ? eb : ea;
    d       = e_big - e_small;
    nan_any = (&a_q[14:10] & |a_q[9:0]) | (&b_q[14:10] & |b_q[9:0]);
    inf_any = (&a_q[14:10] & ~|a_q[9:0]) | (&b_q[14:10] & ~|b_q[9:0]);
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    man_big_d   = man_big_q;
    man_small_d = man_small_q;
    exp_d       = exp_q;
    sign_big_d  = sign_big_q;
    eff_sub_d   = eff_sub_q;
    swapped_d   = swapped_q;
    exception_d = exception_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        man_big_d   = a_big ? ma : mb;
        man_small_d = a_big ? mb : ma;
        exp_d       = {1'b0, e_big};
        sign_big_d  = a_big ? a_q[15] : b_q[15];
        eff_sub_d   = a_q[15] ^ b_q[15];
        swapped_d   = ~a_big;
        exception_d = nan_any ? 2'b11 : (inf_any ? 2'b01 : 2'b00);
        cnt_d       = d;
        flush_d     = d > MAX_D;
        state_d     = (d == 5'd0) ? DONE : ALIGN;
      end
      ALIGN: begin
        if (flush_q) begin
          man_small_d = sticky_flush(man_small_q);
          state_d     = DONE;
        end else begin
          man_small_d = sticky_shr1(man_small_q);
          cnt_d       = cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      man_big_q   <= '0;
      man_small_q <= '0;
      exp_q       <= '0;
      sign_big_q  <= 1'b0;
      eff_sub_q   <= 1'b0;
      swapped_q   <= 1'b0;
      exception_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      man_big_q   <= man_big_d;
      man_small_q <= man_small_d;
      exp_q       <= exp_d;
      sign_big_q  <= sign_big_d;
      eff_sub_q   <= eff_sub_d;
      swapped_q   <= swapped_d;
      exception_q <= exception_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign man_big   = man_big_q;
  assign man_small = man_small_q;
  assign exp       = exp_q;
  assign sign_big  = sign_big_q;
  assign eff_sub   = eff_sub_q;
  assign swapped   = swapped_q;
  assign exception = exception_q;

endmodule

// File: tb/tb_unpack_align.sv
// Directed bench for unpack_align: alignment, latency, specials, back-pressure, reset.
module tb_unpack_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] man_big, man_small;
  logic [5:0]  exp;
  logic        sign_big, eff_sub, swapped;
  logic [1:0]  exception;

  int pass_cnt = 0;
  int total_cnt = 0;

  unpack_align #(.MAX_SHIFT(14)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .man_big(man_big), .man_small(man_small), .exp(exp),
    .sign_big(sign_big), .eff_sub(eff_sub), .swapped(swapped),
    .exception(exception)
  );

  always #5 clk = ~clk;

  // Accept one pair and return the cycle index (accept cycle = 0) of the first out_valid.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, output int lat);
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if ({man_big, man_small} !== 32'h0) $display("FAIL reset_man got %h want 0", {man_big, man_small}); else pass_cnt++;
    total_cnt++; if ({exp, sign_big, eff_sub, swapped, exception} !== 11'h0) $display("FAIL reset_flags got %h want 0", {exp, sign_big, eff_sub, swapped, exception}); else pass_cnt++;
  endtask

  task automatic test_equal();
    int lat;
    run_op(16'h3C00, 16'h3C00, lat);
    total_cnt++; if (lat !== 2) $display("FAIL equal_latency got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (man_big !== 16'h2000) $display("FAIL equal_man_big got %h want 2000", man_big); else pass_cnt++;
    total_cnt++; if (man_small !== 16'h2000) $display("FAIL equal_man_small got %h want 2000", man_small); else pass_cnt++;
    total_cnt++; if (exp !== 6'd15) $display("FAIL equal_exp got %0d want 15", exp); else pass_cnt++;
    total_cnt++; if ({swapped, eff_sub, sign_big, exception} !== 5'b0) $display("FAIL equal_flags got %b want 00000", {swapped, eff_sub, sign_big, exception}); else pass_cnt++;
    release_out();
  endtask

  task automatic test_swap();
    int lat;
    run_op(16'h3C00, 16'h4000, lat);
    total_cnt++; if (lat !== 3) $display("FAIL swap_latency got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (swapped !== 1'b1) $display("FAIL swap_swapped got %b want 1", swapped); else pass_cnt++;
    total_cnt++; if (man_big !== 16'h2000) $display("FAIL swap_man_big got %h want 2000", man_big); else pass_cnt++;
    total_cnt++; if (man_small !== 16'h1000) $display("FAIL swap_man_small got %h want 1000", man_small); else pass_cnt++;
    total_cnt++; if (exp !== 6'd16) $display("FAIL swap_exp got %0d want 16", exp); else pass_cnt++;
    release_out();
  endtask

  task automatic test_denormal();
    int lat;
    run_op(16'h3C00, 16'h0001, lat);
    total_cnt++; if (lat !== 16) $display("FAIL denorm_latency got %0d want 16", lat); else pass_cnt++;
    total_cnt++; if (man_small !== 16'h0001) $display("FAIL denorm_man_small got %h want 0001", man_small); else pass_cnt++;
    total_cnt++; if (man_big !== 16'h2000) $display("FAIL denorm_man_big got %h want 2000", man_big); else pass_cnt++;
    total_cnt++; if (exp !== 6'd15) $display("FAIL denorm_exp got %0d want 15", exp); else pass_cnt++;
    total_cnt++; if (swapped !== 1'b0) $display("FAIL denorm_swapped got %b want 0", swapped); else pass_cnt++;
    release_out();
  endtask

  task automatic test_flush();
    int lat;
    run_op(16'h5C00, 16'hBC00, lat);
    total_cnt++; if (lat !== 10) $display("FAIL shift8_latency got %0d want 10", lat); else pass_cnt++;
    total_cnt++; if (man_small !== 16'h0020) $display("FAIL shift8_man_small got %h want 0020", man_small); else pass_cnt++;
    total_cnt++; if (exp !== 6'd23) $display("FAIL shift8_exp got %0d want 23", exp); else pass_cnt++;
    total_cnt++; if ({eff_sub, sign_big} !== 2'b10) $display("FAIL shift8_signs got %b want 10", {eff_sub, sign_big}); else pass_cnt++;
    release_out();
    run_op(16'h7BFF, 16'h0400, lat);
    total_cnt++; if (lat !== 3) $display("FAIL flush_latency got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (man_small !== 16'h0001) $display("FAIL flush_man_small got %h want 0001", man_small); else pass_cnt++;
    total_cnt++; if (man_big !== 16'h3FF8) $display("FAIL flush_man_big got %h want 3ff8", man_big); else pass_cnt++;
    total_cnt++; if (exp !== 6'd30) $display("FAIL flush_exp got %0d want 30", exp); else pass_cnt++;
    total_cnt++; if (eff_sub !== 1'b0) $display("FAIL flush_eff_sub got %b want 0", eff_sub); else pass_cnt++;
    release_out();
  endtask

  task automatic test_specials();
    int lat;
    run_op(16'h7E00, 16'h3C00, lat);
    total_cnt++; if (exception !== 2'b11) $display("FAIL nan_exception got %b want 11", exception); else pass_cnt++;
    total_cnt++; if (exp !== 6'd31) $display("FAIL nan_exp got %0d want 31", exp); else pass_cnt++;
    release_out();
    run_op(16'h7C00, 16'h3C00, lat);
    total_cnt++; if (exception !== 2'b01) $display("FAIL inf_exception got %b want 01", exception); else pass_cnt++;
    total_cnt++; if (exp !== 6'd31) $display("FAIL inf_exp got %0d want 31", exp); else pass_cnt++;
    total_cnt++; if (man_small !== 16'h0001) $display("FAIL inf_man_small got %h want 0001", man_small); else pass_cnt++;
    release_out();
    run_op(16'h3C00, 16'hFC00, lat);
    total_cnt++; if ({exception, swapped, sign_big, eff_sub} !== 5'b01111) $display("FAIL neginf_flags got %b want 01111", {exception, swapped, sign_big, eff_sub}); else pass_cnt++;
    release_out();
  endtask

  task automatic test_back_pressure();
    int lat;
    run_op(16'h5C00, 16'hBC00, lat);
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || man_small !== 16'h0020 || man_big !== 16'h2000 || exp !== 6'd23)
        $display("FAIL hold_cycle%0d got v=%b r=%b ms=%h mb=%h e=%0d want v=1 r=0 ms=0020 mb=2000 e=23",
                 i, out_valid, in_ready, man_small, man_big, exp);
      else pass_cnt++;
    end
    @(negedge clk); in_valid = 1'b0;
    release_out();
    total_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL release_handshake got %b want 01", {out_valid, in_ready}); else pass_cnt++;
    total_cnt++; if (man_small !== 16'h0020) $display("FAIL idle_hold_man_small got %h want 0020", man_small); else pass_cnt++;
    // Immediately following operation must use fresh operands.
    run_op(16'h3C00, 16'h4000, lat);
    total_cnt++; if (lat !== 3 || man_small !== 16'h1000) $display("FAIL b2b got lat=%0d ms=%h want lat=3 ms=1000", lat, man_small); else pass_cnt++;
    release_out();
  endtask

  task automatic test_reset_align();
    int seen;
    @(negedge clk);
    a = 16'h3C00; b = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL midreset_handshake got %b want 01", {out_valid, in_ready}); else pass_cnt++;
    total_cnt++; if ({man_big, man_small, exp, sign_big, eff_sub, swapped, exception} !== 43'h0) $display("FAIL midreset_outputs got %h want 0", {man_big, man_small, exp, sign_big, eff_sub, swapped, exception}); else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL midreset_no_result got %0d valid cycles want 0", seen); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_swap();
    test_denormal();
    test_flush();
    test_specials();
    test_back_pressure();
    test_reset_align();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
